// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the seven-segment scan decoder.
// Holds the active-low glyph patterns {a,b,c,d,e,f,g}, the 4-bit output codes
// and the anode legality/index helpers used by the decoder and its glyph table.
package sevenseg_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned CODE_W   = 4;
  localparam int unsigned ANODE_W  = 4;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned FRAME_W  = DIGITS * CODE_W;
  localparam int unsigned STABLE_W = 4;

  // Active-low segment patterns, seg[6] = a ... seg[0] = g
  localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] SEG_UP    = 7'b0011101;
  localparam logic [SEG_W-1:0] SEG_DOWN  = 7'b1100011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [CODE_W-1:0] CODE_UP    = 4'hA;
  localparam logic [CODE_W-1:0] CODE_DOWN  = 4'hB;
  localparam logic [CODE_W-1:0] CODE_BLANK = 4'hE;
  localparam logic [CODE_W-1:0] CODE_BAD   = 4'hF;

  localparam logic [ANODE_W-1:0] ANODE_IDLE = 4'b1111;

  // One code per digit slot; slot 3 is the leftmost digit
  typedef logic [DIGITS-1:0][CODE_W-1:0] frame_t;

  // Legal select: exactly one active-low bit
  function automatic logic anode_legal(input logic [ANODE_W-1:0] a);
    return ($countones(~a) == 1);
  endfunction

  // Slot addressed by a legal anode (bit n low -> slot n)
  function automatic logic [1:0] anode_index(input logic [ANODE_W-1:0] a);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < int'(ANODE_W); i++) begin
      if (!a[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational glyph lookup: active-low segment pattern -> 4-bit code.
// Ports: seg (active-low {a..g}), code_c (decoded code), bad_c (unrecognised glyph).
module sevenseg_glyph_decode
  import sevenseg_pkg::*;
(
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] code_c,
  output logic              bad_c
);

  always_comb begin
    code_c = CODE_BAD;
    case (seg)
      SEG_0:     code_c = 4'h0;
      SEG_1:     code_c = 4'h1;
      SEG_2:     code_c = 4'h2;
      SEG_3:     code_c = 4'h3;
      SEG_4:     code_c = 4'h4;
      SEG_5:     code_c = 4'h5;
      SEG_6:     code_c = 4'h6;
      SEG_7:     code_c = 4'h7;
      SEG_8:     code_c = 4'h8;
      SEG_9:     code_c = 4'h9;
      SEG_UP:    code_c = CODE_UP;
      SEG_DOWN:  code_c = CODE_DOWN;
      SEG_BLANK: code_c = CODE_BLANK;
      default:   code_c = CODE_BAD;
    endcase
    // No legal glyph maps to CODE_BAD, so the code alone identifies a bad glyph
    bad_c = (code_c == CODE_BAD);
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Seven-segment scan decoder: watches a multiplexed 4-digit display bus,
// samples each digit once its anode has settled, assembles frames and
// publishes them on digits after STABLE_FRAMES identical frames.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   anode[3:0]   active-low digit select, bit 3 = leftmost digit
//   seg[6:0]     active-low segments {a..g}
//   digits[15:0] published codes, [15:12] = leftmost digit
//   frame_valid  one-cycle pulse when digits updates
//   frame_err    one-cycle pulse on entering an illegal anode pattern
//   seg_err      sticky unrecognised-glyph flag, cleared when digits updates
//   stalled      high while one non-idle anode persists for TIMEOUT cycles
// Build option: define SEVENSEG_STALL_DETECT_EN to enable stall detection;
// otherwise stalled is constant 0 and the dwell counter is only SETTLE-wide.
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned SETTLE        = 4,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned TIMEOUT       = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ANODE_W-1:0] anode,
  input  logic [SEG_W-1:0]   seg,
  output logic [FRAME_W-1:0] digits,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               seg_err,
  output logic               stalled
);

`ifdef SEVENSEG_STALL_DETECT_EN
  localparam int unsigned DWELL_W   = 24;
  localparam int unsigned DWELL_MAX = TIMEOUT;
`else
  localparam int unsigned DWELL_W   = $clog2(SETTLE + 1);
  localparam int unsigned DWELL_MAX = SETTLE;
`endif

  localparam logic [DWELL_W-1:0]  SAMPLE_AT  = DWELL_W'(SETTLE - 1);
  localparam logic [DWELL_W-1:0]  DWELL_SAT  = DWELL_W'(DWELL_MAX);
  localparam logic [STABLE_W-1:0] STABLE_HIT = STABLE_W'(STABLE_FRAMES - 1);
  localparam logic [STABLE_W-1:0] STABLE_SAT = '1;

  // Elaboration-time parameter range checks
  if (SETTLE < 1 || SETTLE > 255) begin : g_settle_check
    $error("SETTLE must be in 1..255");
  end
  if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_stable_check
    $error("STABLE_FRAMES must be in 1..15");
  end
  if (TIMEOUT >= (1 << 24) || TIMEOUT < SETTLE) begin : g_timeout_check
    $error("TIMEOUT must fit in 24 bits and be at least SETTLE");
  end

  // Glyph lookup for whatever is currently on the segment lines
  logic [CODE_W-1:0] glyph_code;
  logic              glyph_bad;

  sevenseg_glyph_decode u_glyph (
    .seg    (seg),
    .code_c (glyph_code),
    .bad_c  (glyph_bad)
  );

  // State
  logic [ANODE_W-1:0]  last_anode;
  logic [DWELL_W-1:0]  dwell;
  logic [DIGITS-1:0]   captured;
  frame_t              slots;
  frame_t              prev_frame;
  logic [STABLE_W-1:0] stable;

  // Next-state
  logic                changed;
  logic                idle;
  logic                illegal;
  logic                sample;
  logic                frame_done;
  logic                load;
  logic [1:0]          slot_idx;
  logic [STABLE_W-1:0] stable_inc;
  logic [DWELL_W-1:0]  dwell_n;
  logic [DIGITS-1:0]   captured_n;
  frame_t              slots_n;
  frame_t              prev_frame_n;
  logic [STABLE_W-1:0] stable_n;
  logic [FRAME_W-1:0]  digits_n;
  logic                frame_valid_n;
  logic                frame_err_n;
  logic                seg_err_n;
  logic                stalled_n;

  // Dwell tracking, sampling, frame assembly and publication
  always_comb begin
    dwell_n       = dwell;
    captured_n    = captured;
    slots_n       = slots;
    prev_frame_n  = prev_frame;
    stable_n      = stable;
    digits_n      = digits;
    frame_valid_n = 1'b0;
    frame_err_n   = 1'b0;
    seg_err_n     = seg_err;
    stalled_n     = 1'b0;

    changed  = (anode != last_anode);
    idle     = (anode == ANODE_IDLE);
    illegal  = !anode_legal(anode) && !idle;
    slot_idx = anode_index(anode);

    if (changed) begin
      dwell_n = '0;
    end else if (dwell != DWELL_SAT) begin
      dwell_n = dwell + DWELL_W'(1);
    end

    // The !changed term keeps a stale count from sampling a freshly selected digit
    sample     = anode_legal(anode) && !changed && (dwell == SAMPLE_AT);
    frame_done = &captured;

    if (slots == prev_frame) begin
      stable_inc = (stable == STABLE_SAT) ? stable : stable + STABLE_W'(1);
    end else begin
      stable_inc = '0;
    end
    load = frame_done && !illegal &&
           ((STABLE_FRAMES == 1) || (stable_inc == STABLE_HIT));

    if (illegal) begin
      // Abandon the partial frame and the stability run; only flag new patterns
      captured_n  = '0;
      stable_n    = '0;
      frame_err_n = changed;
    end else begin
      if (frame_done) begin
        captured_n   = '0;
        stable_n     = stable_inc;
        prev_frame_n = slots;
        if (load) begin
          digits_n      = slots;
          frame_valid_n = 1'b1;
          seg_err_n     = 1'b0;
        end
      end
      if (sample) begin
        slots_n[slot_idx]    = glyph_code;
        captured_n[slot_idx] = 1'b1;
        if (glyph_bad) seg_err_n = 1'b1;
      end
    end

`ifdef SEVENSEG_STALL_DETECT_EN
    // Registered so that stalled is high exactly while dwell sits at TIMEOUT
    stalled_n = (dwell_n == DWELL_SAT) && !idle;
`endif
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_anode  <= ANODE_IDLE;
      dwell       <= '0;
      captured    <= '0;
      slots       <= {DIGITS{CODE_BLANK}};
      prev_frame  <= {DIGITS{CODE_BLANK}};
      stable      <= '0;
      digits      <= {DIGITS{CODE_BLANK}};
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      seg_err     <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      last_anode  <= anode;
      dwell       <= dwell_n;
      captured    <= captured_n;
      slots       <= slots_n;
      prev_frame  <= prev_frame_n;
      stable      <= stable_n;
      digits      <= digits_n;
      frame_valid <= frame_valid_n;
      frame_err   <= frame_err_n;
      seg_err     <= seg_err_n;
      stalled     <= stalled_n;
    end
  end

endmodule

// File: doc/sevenseg_scan_decoder.md
SEVENSEG_SCAN_DECODER -- requirements
Module: sevenseg_scan_decoder

Interface
REQ-001 Parameter SETTLE, default 4: cycles an anode pattern must stay unchanged before its segments are sampled (range 1..255).
REQ-002 Parameter STABLE_FRAMES, default 2: consecutive identical complete frames required before outputs update (range 1..15).
REQ-003 Parameter TIMEOUT, default 1000000: cycles one anode pattern may persist before a stall is flagged (fits in 24 bits).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 anode  input  4  multiplexed digit select, active-low; bit 3 = leftmost digit.
REQ-007 seg  input  7  segment lines, active-low, {a,b,c,d,e,f,g} with seg[6]=a.
REQ-008 digits  output  16  decoded codes, digits[15:12] = leftmost digit.
REQ-009 frame_valid  output  1  one-cycle pulse when digits updates.
REQ-010 frame_err  output  1  one-cycle pulse on an illegal anode pattern.
REQ-011 seg_err  output  1  sticky; set on an unrecognised glyph; cleared on the next frame_valid.
REQ-012 stalled  output  1  level; high while the stall condition holds.

Function
REQ-013 Glyph decode: 0000001..0000100 (digits 0-9, standard active-low table) -> 4'h0..4'h9; 0011101 -> 4'hA (up); 1100011 -> 4'hB (down); 1111111 -> 4'hE (blank); any other pattern -> 4'hF and seg_err is set.
REQ-014 A legal anode has exactly one bit low; 4'b1111 is idle and is neither sampled nor an error; two or more bits low is illegal.
REQ-015 Dwell counter: clears on any change in anode and otherwise increments, saturating at TIMEOUT.
REQ-016 Sampling: when the dwell counter equals SETTLE-1 and anode is legal, decode seg once into that digit's slot and set its captured flag; no second sample is taken in the same dwell.
REQ-017 Frame complete: the cycle after all four captured flags are set; the captured flags then clear in that same cycle.
REQ-018 On frame complete: if the frame equals the previous frame, the stable counter increments (saturating), else it clears to 0; the frame is then stored as the previous frame.
REQ-019 When the stable count after REQ-018 reaches STABLE_FRAMES-1: load digits from the frame and pulse frame_valid the next cycle. With STABLE_FRAMES=1, every complete frame updates digits.
REQ-020 Illegal anode: pulse frame_err, clear all captured flags and the stable counter, sample nothing; previous frame and digits are unchanged.
REQ-021 A slot re-sampled before the frame completes is overwritten by the newer value.
REQ-022 An illegal pattern and a sample cannot coincide; on that cycle the illegal-pattern handling (REQ-020) applies.

Reset
REQ-023 While rst_n=0 at posedge clk: digits=16'hEEEE, frame_valid=0, frame_err=0, seg_err=0, stalled=0, captured flags, dwell and stable counters = 0, previous frame = 16'hEEEE.
REQ-024 Reset asserted mid-frame discards partial captures; the first frame_valid after reset needs STABLE_FRAMES fresh complete frames.

Configuration
REQ-025 Macro SEVENSEG_STALL_DETECT_EN defined: stalled=1 while the dwell counter equals TIMEOUT and anode is not 4'b1111; stalled returns to 0 the cycle after anode changes.
REQ-026 Macro SEVENSEG_STALL_DETECT_EN undefined: stalled is tied to 0, TIMEOUT is unused, and the dwell counter is only SETTLE-wide.

Structure
REQ-027 Package sevenseg_pkg holds the segment-pattern constants, the code constants (CODE_UP=4'hA, CODE_DOWN=4'hB, CODE_BLANK=4'hE, CODE_BAD=4'hF) and the anode-legality function.
REQ-028 Sub-module sevenseg_glyph_decode is purely combinational (seg -> 4-bit code plus bad flag); it is instantiated once.

Verification
REQ-029 Scan "1","2","U","U" (anode 0111,1011,1101,1110), dwell 8 cycles each, STABLE_FRAMES=2 -> frame_valid once, after the second frame; digits=16'h12AA.
REQ-030 Alternate frames 0,5,d,d and 0,6,d,d -> no frame_valid; stable counter stays 0.
REQ-031 Anode 4'b0011 for one cycle mid-frame -> frame_err pulses once; digits unchanged; the next two clean frames give frame_valid.
REQ-032 Seg 7'b1111110 on digit 1 -> that slot = 4'hF, seg_err=1 until the next frame_valid.
REQ-033 SETTLE=4 with 3-cycle dwells -> nothing is sampled and no frame_valid.
REQ-034 With SEVENSEG_STALL_DETECT_EN defined and TIMEOUT=50: hold anode 4'b1011 -> stalled=1 from dwell 50; change anode -> stalled=0 the next cycle.
